// File: rtl/snake_pkg.sv
// ============================================================================
// Module   : snake_pkg
// Brief    : Shared types and helpers for the snake body controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snake_pkg;

    localparam int DEF_MAX_LEN = 50;

    typedef logic [7:0] coord_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Encoding pairs UP/DOWN and LEFT/RIGHT on bit 0.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    function automatic coord_t next_cord(input coord_t c, input dir_t d);
        logic [3:0] nx;
        logic [3:0] ny;
        nx = c[7:4];
        ny = c[3:0];
        case (d)
            DIR_UP:   ny = ny - 4'd1;
            DIR_DOWN: ny = ny + 4'd1;
            DIR_LEFT: nx = nx - 4'd1;
            default:  nx = nx + 4'd1;
        endcase
        return {nx, ny};
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_hit_detect.sv
// ============================================================================
// Module   : snake_hit_detect
// Brief    : Compares a coordinate against the live body and an apple.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_hit_detect
    import snake_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic [7:0]               i_cord,
    input  logic [7:0]               i_apple,
    input  logic [MAX_LEN-1:0][7:0]  i_body,
    input  logic [5:0]               i_length,
    output logic                     o_self_hit,
    output logic                     o_grow
);

    // The tail entry only counts when the coordinate also matches the apple.
    always_comb begin
        o_grow     = (i_cord == i_apple);
        o_self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i_body[i] == i_cord &&
                (i < int'(i_length) - 1 || (i == int'(i_length) - 1 && o_grow))) begin
                o_self_hit = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/snake_body_ctrl.sv
// ============================================================================
// Module   : snake_body_ctrl
// Brief    : Snake body shift register, length, movement, collisions, pixel flag.
//            Define WRAP_WALLS_EN to wrap edges modulo 16 (only self hits kill).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int         MAX_LEN    = DEF_MAX_LEN,
    parameter int         INIT_LEN   = 3,
    parameter logic [7:0] START_CORD = 8'h88
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     move_tick,
    input  logic [1:0]               dir_in,
    input  logic [7:0]               apple_cord,
    input  logic [3:0]               x,
    input  logic [3:0]               y,
    output logic [MAX_LEN-1:0][7:0]  body,
    output logic [5:0]               length,
    output logic                     good_coll,
    output logic                     bad_coll,
    output logic                     dead,
    output logic                     snake_px
);

    state_t                    r_state, w_state_nxt;
    dir_t                      r_dir, r_pend, w_commit;
    logic [5:0]                r_len, w_new_len;
    logic [MAX_LEN-1:0][7:0]   r_body, w_shift, w_init_body;
    logic                      r_good, r_bad, r_px;
    coord_t                    w_nh, w_new_tail;
    logic                      w_self, w_grow, w_wall, w_hit, w_step, w_init;
    logic                      w_px_hit, w_px_tail;

    assign w_step   = move_tick && (r_state == ST_RUN);
    assign w_init   = start && (r_state != ST_RUN);
    assign w_commit = w_step ? r_pend : r_dir;
    assign w_nh     = next_cord(r_body[0], r_pend);
    assign w_hit    = w_wall || w_self;

`ifdef WRAP_WALLS_EN
    assign w_wall = 1'b0;
`else
    always_comb begin
        case (r_pend)
            DIR_UP:   w_wall = (r_body[0][3:0] == 4'h0);
            DIR_DOWN: w_wall = (r_body[0][3:0] == 4'hF);
            DIR_LEFT: w_wall = (r_body[0][7:4] == 4'h0);
            default:  w_wall = (r_body[0][7:4] == 4'hF);
        endcase
    end
`endif

    snake_hit_detect #(.MAX_LEN(MAX_LEN)) u_move_hit (
        .i_cord     (w_nh),
        .i_apple    (apple_cord),
        .i_body     (r_body),
        .i_length   (r_len),
        .o_self_hit (w_self),
        .o_grow     (w_grow)
    );

    // Feeding the tail in as the "apple" makes the detector cover every live entry.
    snake_hit_detect #(.MAX_LEN(MAX_LEN)) u_px_hit (
        .i_cord     ({x, y}),
        .i_apple    (r_body[r_len - 6'd1]),
        .i_body     (r_body),
        .i_length   (r_len),
        .o_self_hit (w_px_hit),
        .o_grow     (w_px_tail)
    );

    always_comb begin
        w_new_len  = (w_grow && r_len < 6'(MAX_LEN)) ? r_len + 6'd1 : r_len;
        w_new_tail = r_body[w_new_len - 6'd2];
        w_shift[0] = w_nh;
        for (int i = 1; i < MAX_LEN; i++) begin
            w_shift[i] = (i < int'(w_new_len)) ? r_body[i-1] : w_new_tail;
        end
        for (int i = 0; i < MAX_LEN; i++) begin
            w_init_body[i] = (i < INIT_LEN) ? START_CORD - 8'(i << 4)
                                            : START_CORD - 8'((INIT_LEN - 1) << 4);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_step && w_hit) w_state_nxt = ST_DEAD;
            ST_DEAD: if (start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_RIGHT;
            r_pend  <= DIR_RIGHT;
            r_len   <= 6'(INIT_LEN);
            r_body  <= w_init_body;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
            r_px    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_step && !w_hit && w_grow;
            r_bad   <= w_step && w_hit;
            r_px    <= w_px_hit || w_px_tail;
            if (w_init) begin
                r_dir  <= DIR_RIGHT;
                r_pend <= DIR_RIGHT;
                r_len  <= 6'(INIT_LEN);
                r_body <= w_init_body;
            end else begin
                if (dir_t'(dir_in) != opposite(w_commit)) begin
                    r_pend <= dir_t'(dir_in);
                end
                if (w_step) begin
                    r_dir <= r_pend;
                    if (!w_hit) begin
                        r_body <= w_shift;
                        r_len  <= w_new_len;
                    end
                end
            end
        end
    end

    assign body      = r_body;
    assign length    = r_len;
    assign good_coll = r_good;
    assign bad_coll  = r_bad;
    assign dead      = (r_state == ST_DEAD);
    assign snake_px  = r_px;

endmodule

`default_nettype wire

// File: tb/tb_snake_body_ctrl.sv
// ============================================================================
// Module   : tb_snake_body_ctrl
// Brief    : Directed self-checking bench for snake_body_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_body_ctrl;

    logic             clk;
    logic             reset;
    logic             start;
    logic             move_tick;
    logic [1:0]       dir_in;
    logic [7:0]       apple_cord;
    logic [3:0]       x;
    logic [3:0]       y;
    logic [49:0][7:0] body;
    logic [5:0]       length;
    logic             good_coll;
    logic             bad_coll;
    logic             dead;
    logic             snake_px;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

    snake_body_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .move_tick  (move_tick),
        .dir_in     (dir_in),
        .apple_cord (apple_cord),
        .x          (x),
        .y          (y),
        .body       (body),
        .length     (length),
        .good_coll  (good_coll),
        .bad_coll   (bad_coll),
        .dead       (dead),
        .snake_px   (snake_px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    task automatic step(input logic [1:0] d, input logic [7:0] apple);
        dir_in = d;
        @(negedge clk);
        apple_cord = apple;
        tick();
    endtask

    task automatic restart();
        reset = 1'b0;
        dir_in = RIGHT;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (body[0] !== 8'h88) begin errors++; $display("FAIL reset_b0 got %h exp 88", body[0]); end
        checks++; if (body[1] !== 8'h78) begin errors++; $display("FAIL reset_b1 got %h exp 78", body[1]); end
        checks++; if (body[2] !== 8'h68) begin errors++; $display("FAIL reset_b2 got %h exp 68", body[2]); end
        for (int i = 3; i < 50; i++) begin
            checks++; if (body[i] !== 8'h68) begin errors++; $display("FAIL reset_tail[%0d] got %h exp 68", i, body[i]); end
        end
        checks++; if (length !== 6'd3) begin errors++; $display("FAIL reset_len got %0d exp 3", length); end
        checks++; if ({dead, good_coll, bad_coll, snake_px} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {dead, good_coll, bad_coll, snake_px}); end
        reset = 1'b1;
        x = 4'h6; y = 4'h8;
        @(negedge clk);
        x = 4'h5;
        checks++; if (snake_px !== 1'b1) begin errors++; $display("FAIL px_tail got %b exp 1", snake_px); end
        @(negedge clk);
        x = 4'h8;
        checks++; if (snake_px !== 1'b0) begin errors++; $display("FAIL px_empty got %b exp 0", snake_px); end
        @(negedge clk);
        checks++; if (snake_px !== 1'b1) begin errors++; $display("FAIL px_head got %b exp 1", snake_px); end
        tick();
        checks++; if (body[0] !== 8'h88) begin errors++; $display("FAIL idle_tick got %h exp 88", body[0]); end
    endtask

    task automatic test_wall();
        logic [7:0] exp_h;
        apple_cord = 8'h00;
        dir_in = RIGHT;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_h = 8'h88;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_h = exp_h + 8'h10;
            checks++; if (body[0] !== exp_h || bad_coll !== 1'b0) begin
                errors++; $display("FAIL walk%0d got %h/%b exp %h/0", k, body[0], bad_coll, exp_h); end
        end
        tick();
`ifdef WRAP_WALLS_EN
        checks++; if (body[0] !== 8'h08 || bad_coll !== 1'b0 || dead !== 1'b0) begin
            errors++; $display("FAIL wrap got %h/%b/%b exp 08/0/0", body[0], bad_coll, dead); end
`else
        checks++; if (bad_coll !== 1'b1 || dead !== 1'b1) begin
            errors++; $display("FAIL wall_hit got bad=%b dead=%b exp 1/1", bad_coll, dead); end
        checks++; if (body[0] !== 8'hF8 || body[2] !== 8'hD8 || length !== 6'd3) begin
            errors++; $display("FAIL wall_frozen got %h %h %0d exp F8 D8 3", body[0], body[2], length); end
        @(negedge clk);
        checks++; if (bad_coll !== 1'b0) begin errors++; $display("FAIL wall_pulse got %b exp 0", bad_coll); end
        tick();
        checks++; if (body[0] !== 8'hF8 || dead !== 1'b1) begin
            errors++; $display("FAIL dead_tick got %h/%b exp F8/1", body[0], dead); end
        start = 1'b1;
        move_tick = 1'b1;
        @(negedge clk);
        start = 1'b0;
        move_tick = 1'b0;
        checks++; if (body[0] !== 8'h88 || body[2] !== 8'h68 || length !== 6'd3 || dead !== 1'b0) begin
            errors++; $display("FAIL restart got %h %h %0d %b exp 88 68 3 0", body[0], body[2], length, dead); end
`endif
    endtask

    task automatic test_grow_loop();
        restart();
        step(RIGHT, 8'h98);
        checks++; if (good_coll !== 1'b1 || length !== 6'd4) begin
            errors++; $display("FAIL grow got good=%b len=%0d exp 1/4", good_coll, length); end
        checks++; if (body[0] !== 8'h98 || body[3] !== 8'h68 || body[4] !== 8'h68) begin
            errors++; $display("FAIL grow_body got %h %h %h exp 98 68 68", body[0], body[3], body[4]); end
        @(negedge clk);
        checks++; if (good_coll !== 1'b0) begin errors++; $display("FAIL grow_pulse got %b exp 0", good_coll); end
        step(LEFT, 8'h00);
        checks++; if (body[0] !== 8'hA8 || bad_coll !== 1'b0) begin
            errors++; $display("FAIL reversal got %h/%b exp A8/0", body[0], bad_coll); end
        step(DOWN, 8'h00);
        step(LEFT, 8'h00);
        checks++; if (body[0] !== 8'h99 || body[3] !== 8'h98) begin
            errors++; $display("FAIL loop4_mid got %h %h exp 99 98", body[0], body[3]); end
        step(UP, 8'h00);
        checks++; if (body[0] !== 8'h98 || bad_coll !== 1'b0) begin
            errors++; $display("FAIL loop4_tail got %h/%b exp 98/0", body[0], bad_coll); end
        step(RIGHT, 8'h00);
        checks++; if (body[0] !== 8'hA8 || dead !== 1'b0 || length !== 6'd4) begin
            errors++; $display("FAIL loop4_end got %h/%b/%0d exp A8/0/4", body[0], dead, length); end
        step(RIGHT, 8'hB8);
        checks++; if (length !== 6'd5 || body[4] !== 8'hA9) begin
            errors++; $display("FAIL grow5 got %0d %h exp 5 A9", length, body[4]); end
        step(DOWN, 8'h00);
        step(LEFT, 8'h00);
        step(UP, 8'h00);
        checks++; if (bad_coll !== 1'b1 || dead !== 1'b1 || good_coll !== 1'b0) begin
            errors++; $display("FAIL loop5 got bad=%b dead=%b good=%b exp 1/1/0", bad_coll, dead, good_coll); end
        checks++; if (body[0] !== 8'hA9 || body[3] !== 8'hA8) begin
            errors++; $display("FAIL loop5_frozen got %h %h exp A9 A8", body[0], body[3]); end
        x = 4'hB; y = 4'h9;
        @(negedge clk);
        x = 4'hC;
        checks++; if (snake_px !== 1'b1) begin errors++; $display("FAIL px_dead got %b exp 1", snake_px); end
        @(negedge clk);
        checks++; if (snake_px !== 1'b0) begin errors++; $display("FAIL px_dead_off got %b exp 0", snake_px); end
    endtask

    task automatic test_max_len();
        logic [7:0] hist[$];
        logic [3:0] hx, hy;
        logic [1:0] d;
        int exp_len;
        restart();
        hist = '{8'h88, 8'h78, 8'h68};
        hx = 4'h8; hy = 4'h8;
        exp_len = 3;
        for (int s = 0; s < 48; s++) begin
            if (hy[0] == 1'b0) d = (hx == 4'hF) ? DOWN : RIGHT;
            else               d = (hx == 4'h0) ? DOWN : LEFT;
            if (d == DOWN)       hy = hy + 4'd1;
            else if (d == RIGHT) hx = hx + 4'd1;
            else                 hx = hx - 4'd1;
            step(d, {hx, hy});
            exp_len = (exp_len < 50) ? exp_len + 1 : 50;
            hist.push_front({hx, hy});
            while (hist.size() > exp_len) hist.pop_back();
            checks++; if (good_coll !== 1'b1 || length !== 6'(exp_len) || body[0] !== {hx, hy}) begin
                errors++; $display("FAIL eat%0d got good=%b len=%0d head=%h exp 1 %0d %h",
                                   s, good_coll, length, body[0], exp_len, {hx, hy}); end
        end
        for (int i = 0; i < 50; i++) begin
            checks++; if (body[i] !== hist[i]) begin
                errors++; $display("FAIL max_body[%0d] got %h exp %h", i, body[i], hist[i]); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++; if (body[0] !== 8'h88 || body[49] !== 8'h68 || length !== 6'd3 || dead !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %h %h %0d %b exp 88 68 3 0", body[0], body[49], length, dead); end
        tick();
        checks++; if (body[0] !== 8'h88 || good_coll !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle got %h/%b exp 88/0", body[0], good_coll); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; move_tick = 1'b0;
        dir_in = RIGHT; apple_cord = 8'h00; x = 4'h0; y = 4'h0;
        @(negedge clk);
        test_reset();
        test_wall();
        test_grow_loop();
        test_max_len();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
